// File: rtl/muldiv_if.sv
// Multiply/divide unit bundle between the EX control path and ex_muldiv_seq.
//   master (EX side): drives start/op/A/B, flush, read_req, wr_hi/wr_lo/wdata
//   slave  (unit)   : drives hi/lo, busy, done, stall
interface muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             flush;
  logic             read_req;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;

  modport master (
    output start, op, A, B, flush, read_req, wr_hi, wr_lo, wdata,
    input  hi, lo, busy, done, stall
  );

  modport slave (
    input  start, op, A, B, flush, read_req, wr_hi, wr_lo, wdata,
    output hi, lo, busy, done, stall
  );
endinterface

// File: rtl/ex_muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// Ports:
//   clk    - pipeline clock, rising edge
//   reset  - asynchronous active-low reset
//   mdu    - muldiv_if.slave: op request, flush, MFHI/MFLO/MTHI/MTLO
//            hazard inputs; hi/lo/busy/done out, combinational stall out
// Build option: define MULDIV_DIV_EN to include the restoring divider;
// without it, divide requests are ignored.
module ex_muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input logic      clk,
  input logic      reset,
  muldiv_if.slave  mdu
);

  localparam int unsigned CNT_W = 6;
  localparam int unsigned ACC_W = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;     // product, or {rem, quot}
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic               neg_q, neg_d;     // product / quotient sign
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
`ifdef MULDIV_DIV_EN
  logic               div_q, div_d;
  logic               zero_q, zero_d;   // divide by zero
  logic               rneg_q, rneg_d;   // remainder sign (dividend sign)
  logic [WIDTH-1:0]   araw_q, araw_d;   // raw dividend for divide by zero
`endif

  logic               a_neg, b_neg, accept;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [ACC_W-1:0]   mul_next, prod;

  // Operand magnitudes; only signed ops see a sign bit.
  assign a_neg = mdu.op[0] & mdu.A[WIDTH-1];
  assign b_neg = mdu.op[0] & mdu.B[WIDTH-1];
  assign a_mag = a_neg ? -mdu.A : mdu.A;
  assign b_mag = b_neg ? -mdu.B : mdu.B;

`ifdef MULDIV_DIV_EN
  assign accept = mdu.start & ~mdu.flush;
`else
  assign accept = mdu.start & ~mdu.flush & ~mdu.op[1];
`endif

  // Shift-add step: add multiplicand on multiplier LSB, shift right with carry.
  assign mul_sum  = {1'b0, acc_q[ACC_W-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign prod     = neg_q ? -acc_q : acc_q;

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]     div_r1;
  logic [WIDTH-1:0]   div_diff, quot, rem;
  logic               div_ge;
  logic [ACC_W-1:0]   div_next;

  // Restoring step: shift {rem, quot} left, subtract divisor if it fits.
  assign div_r1   = {acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge   = div_r1 >= {1'b0, opnd_q};
  assign div_diff = div_r1[WIDTH-1:0] - opnd_q;
  assign div_next = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                           : {div_r1[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
  assign quot     = acc_q[WIDTH-1:0];
  assign rem      = acc_q[ACC_W-1:WIDTH];
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
`ifdef MULDIV_DIV_EN
    div_d   = div_q;
    zero_d  = zero_q;
    rneg_d  = rneg_q;
    araw_d  = araw_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (mdu.wr_hi) hi_d = mdu.wdata;
        if (mdu.wr_lo) lo_d = mdu.wdata;
        if (accept) begin
          state_d = CALC;
          neg_d   = a_neg ^ b_neg;
          if (mdu.op[1]) begin
            opnd_d = b_mag;
            acc_d  = {WIDTH'(0), a_mag};
          end else begin
            opnd_d = a_mag;
            acc_d  = {WIDTH'(0), b_mag};
          end
`ifdef MULDIV_DIV_EN
          div_d  = mdu.op[1];
          zero_d = (mdu.B == '0);
          rneg_d = a_neg;
          araw_d = mdu.A;
`endif
        end
      end
      CALC: begin
        if (mdu.flush) begin
          state_d = IDLE;
        end else begin
`ifdef MULDIV_DIV_EN
          acc_d = div_q ? div_next : mul_next;
`else
          acc_d = mul_next;
`endif
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!mdu.flush) begin
          done_d = 1'b1;
`ifdef MULDIV_DIV_EN
          if (div_q) begin
            if (zero_q) begin
              hi_d = araw_q;
              lo_d = '1;
            end else begin
              // Overflow case falls out: negating 0x80..0 yields itself.
              hi_d = rneg_q ? -rem  : rem;
              lo_d = neg_q  ? -quot : quot;
            end
          end else begin
            {hi_d, lo_d} = prod;
          end
`else
          {hi_d, lo_d} = prod;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
      div_q   <= 1'b0;
      zero_q  <= 1'b0;
      rneg_q  <= 1'b0;
      araw_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
`ifdef MULDIV_DIV_EN
      div_q   <= div_d;
      zero_q  <= zero_d;
      rneg_q  <= rneg_d;
      araw_q  <= araw_d;
`endif
    end
  end

  assign mdu.hi    = hi_q;
  assign mdu.lo    = lo_q;
  assign mdu.done  = done_q;
  assign mdu.busy  = (state_q != IDLE);
  // Hazard stall: any HI/LO or unit user in EX while an op is in flight.
  assign mdu.stall = (state_q != IDLE) &
                     (mdu.start | mdu.read_req | mdu.wr_hi | mdu.wr_lo);

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Self-checking bench for ex_muldiv_seq: directed cases plus random ops
// against an arithmetic reference model of HI/LO.
module tb_ex_muldiv_seq;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] mhi = '0, mlo = '0;

  muldiv_if #(.WIDTH(32)) bus ();

  ex_muldiv_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (rst_n),
    .mdu   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural operands.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (o)
      2'b00: return ua * ub;
      2'b01: return 64'(sa * sb);
      default: begin
        if (!DIV_EN) return {mhi, mlo};
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (o == 2'b10) return {32'(ua % ub), 32'(ua / ub)};
        q = sa / sb;
        r = sa % sb;
        return {32'(r), 32'(q)};
      end
    endcase
  endfunction

  // Present a start for one edge; returns at the negedge after that edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.op = o; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Bounded wait for done; n = negedge count since the start edge.
  task automatic wait_done(output int n, output int bc);
    n = 1; bc = 0;
    while (!bus.done && n < 60) begin
      if (bus.busy) bc++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [63:0] exp;
    int n, bc;
    exp = model(o, a, b);
    issue(o, a, b);
    if (DIV_EN || !o[1]) begin
      wait_done(n, bc);
      chk({tag, ".latency"}, 64'(n), 64'd34);
      chk({tag, ".busy_cycles"}, 64'(bc), 64'd33);
      chk({tag, ".busy_at_done"}, 64'(bus.busy), 64'd0);
      chk({tag, ".hi"}, 64'(bus.hi), 64'(exp[63:32]));
      chk({tag, ".lo"}, 64'(bus.lo), 64'(exp[31:0]));
      mhi = exp[63:32];
      mlo = exp[31:0];
    end else begin
      chk({tag, ".ignored_busy"}, 64'(bus.busy), 64'd0);
      repeat (2) @(negedge clk);
      chk({tag, ".ignored_done"}, 64'(bus.done), 64'd0);
      chk({tag, ".ignored_hi"}, 64'(bus.hi), 64'(mhi));
      chk({tag, ".ignored_lo"}, 64'(bus.lo), 64'(mlo));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bc, k, sc, dseen;
    logic [1:0]  o;
    logic [31:0] a, b, prior;

    bus.start = 0; bus.op = 0; bus.A = 0; bus.B = 0; bus.flush = 0;
    bus.read_req = 1; bus.wr_hi = 0; bus.wr_lo = 0; bus.wdata = 0;
    bus.start = 1;
    #12;
    chk("reset.hi", 64'(bus.hi), 64'd0);
    chk("reset.lo", 64'(bus.lo), 64'd0);
    chk("reset.busy", 64'(bus.busy), 64'd0);
    chk("reset.done", 64'(bus.done), 64'd0);
    chk("reset.stall", 64'(bus.stall), 64'd0);
    bus.start = 0; bus.read_req = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed arithmetic cases.
    run_op(2'b00, 32'd7, 32'd6, "multu_7x6");
    @(negedge clk);
    chk("multu_7x6.done_one_cycle", 64'(bus.done), 64'd0);
    run_op(2'b01, 32'hFFFF_FFFD, 32'd5, "mult_m3x5");
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, "div_m7d2");
    run_op(2'b10, 32'd100, 32'd0, "divu_by0");
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(2'b11, 32'd1234, 32'd0, "div_by0_signed");

    // Random operations, issued back-to-back in the done cycle.
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
      run_op(o, a, b, "rand");
    end

    // MTHI/MTLO in IDLE.
    @(negedge clk);
    bus.wr_hi = 1; bus.wr_lo = 1; bus.wdata = 32'h0000_0033;
    @(negedge clk);
    bus.wr_hi = 0; bus.wr_lo = 0;
    chk("mt.hi", 64'(bus.hi), 64'h33);
    chk("mt.lo", 64'(bus.lo), 64'h33);
    mhi = 32'h33; mlo = 32'h33;

    // MTHI alongside start: applied now, overwritten at FIX.
    bus.wr_hi = 1; bus.wdata = 32'h55;
    issue(2'b00, 32'd5, 32'd5);
    bus.wr_hi = 0;
    chk("mt_with_start.hi_now", 64'(bus.hi), 64'h55);
    wait_done(n, bc);
    chk("mt_with_start.hi", 64'(bus.hi), 64'h0);
    chk("mt_with_start.lo", 64'(bus.lo), 64'd25);
    mhi = 32'h0; mlo = 32'd25;
    @(negedge clk);

    // MFLO held from the start cycle; MTLO while busy is blocked.
    prior = bus.lo;
    bus.read_req = 1;
    issue(2'b00, 32'd3, 32'd4);
    k = 1; sc = 0;
    while (bus.busy && k < 60) begin
      if (bus.stall) sc++;
      if (k == 5) begin bus.wr_lo = 1; bus.wdata = 32'hDEAD; end
      @(negedge clk);
      k++;
      if (k == 6) begin
        chk("stall.wr_lo_blocked", 64'(bus.lo), 64'(prior));
        bus.wr_lo = 0;
      end
    end
    chk("stall.cycles", 64'(sc), 64'd33);
    chk("stall.done_cycle_stall", 64'(bus.stall), 64'd0);
    chk("stall.done_cycle_done", 64'(bus.done), 64'd1);
    chk("stall.lo", 64'(bus.lo), 64'd12);
    bus.read_req = 0;
    mhi = 32'h0; mlo = 32'd12;
    @(negedge clk);

    // Flush on the 10th CALC cycle.
    bus.wr_hi = 1; bus.wr_lo = 1; bus.wdata = 32'h11;
    @(negedge clk);
    bus.wr_hi = 0; bus.wdata = 32'h22;
    @(negedge clk);
    bus.wr_lo = 0;
    issue(2'b00, 32'hFFFF_FFFF, 32'd2);
    repeat (9) @(negedge clk);
    bus.flush = 1;
    @(negedge clk);
    bus.flush = 0;
    chk("flush.busy", 64'(bus.busy), 64'd0);
    dseen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) dseen++;
      @(negedge clk);
    end
    chk("flush.no_done", 64'(dseen), 64'd0);
    chk("flush.hi", 64'(bus.hi), 64'h11);
    chk("flush.lo", 64'(bus.lo), 64'h22);
    mhi = 32'h11; mlo = 32'h22;

    // Asynchronous reset mid-CALC.
    issue(2'b00, 32'd123, 32'd456);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.hi", 64'(bus.hi), 64'd0);
    chk("rst_mid.lo", 64'(bus.lo), 64'd0);
    chk("rst_mid.busy", 64'(bus.busy), 64'd0);
    chk("rst_mid.done", 64'(bus.done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mhi = 32'h0; mlo = 32'h0;
    @(negedge clk);
    run_op(2'b00, 32'd2, 32'd2, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
